// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - riscv-tests end-of-test detector; optional tohost snoop via RISCV_TEST_MONITOR_TOHOST_EN
module riscv_test_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] PASS_PC     = 'h44,
  parameter int unsigned     TIMEOUT     = 6000,
  parameter int unsigned     HOLD_CYCLES = 1,
  parameter int unsigned     CNT_W       = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  gp,
`ifdef RISCV_TEST_MONITOR_TOHOST_EN
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
`endif
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-2:0]  fail_test_num,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_PASS    = 2'b01,
    S_FAIL    = 2'b10,
    S_TIMEOUT = 2'b11
  } state_e;

  localparam logic [3:0]       HOLD_LAST    = 4'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TIMEOUT_EN   = (TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-2:0]  ftn_q, ftn_d;

  logic            pc_match;
  logic            complete;
  logic            to_hit;
  logic [XLEN-1:0] result;

  assign pc_match = (if_pc == PASS_PC);

`ifdef RISCV_TEST_MONITOR_TOHOST_EN
  logic st_hit;
  // A tohost store overrides any same-cycle PC completion as the result source.
  assign st_hit   = st_valid && (st_addr == TOHOST_ADDR);
  assign result   = st_hit ? st_data : gp;
  assign complete = st_hit || (pc_match && (hold_q == HOLD_LAST));
`else
  assign result   = gp;
  assign complete = pc_match && (hold_q == HOLD_LAST);
`endif

  assign to_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    ftn_d   = ftn_q;
    if (state_q == S_RUN && en) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      hold_d = pc_match ? hold_q + 4'd1 : 4'd0;
      // Completion takes priority over a timeout landing on the same cycle.
      if (complete) begin
        if (result == XLEN'(1)) begin
          state_d = S_PASS;
        end else begin
          state_d = S_FAIL;
          ftn_d   = result[XLEN-1:1];
        end
      end else if (to_hit) begin
        state_d = S_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
      hold_q  <= '0;
      cnt_q   <= '0;
      ftn_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      ftn_q   <= ftn_d;
    end
  end

  assign state         = state_q;
  assign done          = (state_q != S_RUN);
  assign pass          = (state_q == S_PASS);
  assign fail          = (state_q == S_FAIL);
  assign timeout       = (state_q == S_TIMEOUT);
  assign fail_test_num = ftn_q;
  assign cycle_count   = cnt_q;

endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
- Synthesizable end-of-test detector for riscv-tests (rv32ui-p-*) runs on the pipelined Core.
- Watches the fetch PC and the gp register (x3) and declares pass, fail or timeout; results are sticky until reset.
- Reports a cycle count and the failing test number.
- Replaces per-test hard-coded PC/gp/tick checks; every test-specific constant is a parameter.

Parameters:
XLEN, 32, datapath width of PC and gp
PASS_PC, 32'h44, fetch PC that marks test completion
TIMEOUT, 6000, cycle budget; 0 disables timeout
HOLD_CYCLES, 1, consecutive cycles if_pc must equal PASS_PC before completion is declared (1..15)
CNT_W, 32, width of cycle counter
TOHOST_ADDR, 32'h1000, store address snooped when the optional feature is enabled

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset, synchronous, active-low (rst==0 at posedge resets)
en  in  1  count/observe enable; 0 freezes the counters and hold tracking
if_pc  in  XLEN  fetch-stage PC of Core
gp  in  XLEN  architectural x3 value
done  out  1  sticky, set on any terminal state
pass  out  1  sticky, gp==1 at completion
fail  out  1  sticky, gp!=1 at completion
timeout  out  1  sticky, budget exhausted before completion
fail_test_num  out  XLEN-1  gp[XLEN-1:1] captured at completion
cycle_count  out  CNT_W  enabled cycles since reset, frozen at done
state  out  2  00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT

Behaviour:
- Reset (rst==0 at posedge): state=RUN; done/pass/fail/timeout=0; fail_test_num=0; cycle_count=0; hold counter=0.
- A reset asserted in any state, including mid-run or terminal, returns the block to these values on that edge.
- RUN with en=1:
  - cycle_count increments by 1, saturating at all-ones without wrapping.
  - hold counter increments when if_pc==PASS_PC and clears to 0 otherwise.
- Completion condition: if_pc==PASS_PC and the hold counter equals HOLD_CYCLES-1 in the same cycle.
  - With HOLD_CYCLES=1, completion is the first matching cycle.
  - On the completion edge, sample gp:
    - gp==1: state goes to PASS and pass is set.
    - otherwise: state goes to FAIL, fail is set, fail_test_num gets gp[XLEN-1:1].
  - done is set on that same edge.
  - Outputs are registered: they are visible 1 cycle after the matching if_pc cycle.
- Timeout: in RUN with en=1, TIMEOUT!=0, no completion, and cycle_count==TIMEOUT-1. The state goes to TIMEOUT and both timeout and done are set.
  - With TIMEOUT=6000, timeout is asserted after the 6000th enabled cycle.
- Simultaneous completion and timeout on the same cycle: completion wins and timeout stays 0.
- en=0: no state change, cycle_count and hold counter hold, and no completion or timeout is detected.
- A non-matching PC interrupts the hold run: the counter restarts from 0 at the next match.
- Terminal states (PASS/FAIL/TIMEOUT) are absorbing until reset. All outputs, including cycle_count, hold their values, and further if_pc/gp activity is ignored.
- Exactly one of pass/fail/timeout is 1 whenever done=1. All are 0 while done=0.

Optional Feature:
- Macro: RISCV_TEST_MONITOR_TOHOST_EN.
- Defined: adds ports st_valid (in, 1), st_addr (in, XLEN) and st_data (in, XLEN).
  - In RUN with en=1, st_valid=1 and st_addr==TOHOST_ADDR is a completion event, with st_data used in place of gp.
  - It sets pass if st_data==1, otherwise fail with fail_test_num=st_data[XLEN-1:1].
  - It takes effect on the same edge, independent of HOLD_CYCLES.
  - If a tohost store and a PC completion occur in the same cycle, the tohost store decides the result.
- Undefined: these ports do not exist and only PC-based completion applies.

Test Plan:
- Reset, en=1, if_pc=0x44 on cycle 10 with gp=1 -> pass=1, done=1, state=01, cycle_count=11 one cycle later; values held for 100 further cycles.
- if_pc=0x44 with gp=0x7 -> fail=1, fail_test_num=3, state=10, pass=0.
- if_pc never 0x44, TIMEOUT=20 -> timeout=1 after the 20th enabled cycle, cycle_count=20, state=11.
- HOLD_CYCLES=3, pattern 0x44,0x44,0x48,0x44,0x44,0x44 with gp=1 -> done rises only after the sixth cycle; en=0 for 5 cycles mid-pattern delays it by exactly 5 cycles.
- TIMEOUT=10 with if_pc=0x44 on exactly the 10th cycle -> pass=1, timeout=0; rst=0 asserted while in PASS -> all outputs 0 on that edge and counting restarts.
- RISCV_TEST_MONITOR_TOHOST_EN defined, TOHOST_ADDR=0x1000: store st_addr=0x1000, st_data=0xB -> fail=1, fail_test_num=5; with st_data=1 -> pass=1.
